a23_cache_flush_ctrl: RTL and testbench

Sequences whole-cache invalidation for the Amber 2 core's unified cache. Triggers are the CP15 register-1 flush pulse, a write to a disruptive 2 MB region, and the release of reset. It sits between the CP15 coprocessor, the core's fetch-stall network and the cache tag RAM. It owns the tag write port while sweeping and holds the pipeline stalled until every line is invalid.

---
 rtl/a23_cache_pkg.sv | 21 ++
 rtl/a23_flush_trigger.sv | 35 +++
 rtl/a23_cache_flush_ctrl.sv | 99 +++++++++
 tb/tb_a23_cache_flush_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a23_cache_pkg.sv
// Shared definitions for the Amber 2 unified cache and its flush controller:
// flush FSM encoding, the 2 MB region field of a core address, and the
// default cache geometry.
package a23_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FILL = 2'd1,
    ST_SWEEP     = 2'd2,
    ST_DONE      = 2'd3
  } flush_state_e;

  // Address bits selecting one of 32 regions of 2 MB each.
  localparam int REGION_MSB = 25;
  localparam int REGION_LSB = 21;

  // Cache geometry shared between the cache and the flush controller.
  localparam int A23_CACHE_LINES = 256;
  localparam int A23_CACHE_WAYS  = 4;

endpackage

// File: rtl/a23_flush_trigger.sv
// Purely combinational flush trigger decode: CP15 flush pulse, optionally
// ORed with a core write landing in a region marked disruptive.
// Build option: A23_FLUSH_DISRUPTIVE_EN enables the disruptive-region source;
// without it only i_flush_req triggers and the core access inputs are ignored.
module a23_flush_trigger
  import a23_cache_pkg::*;
(
  input  logic        i_flush_req,
  input  logic        i_core_req,
  input  logic        i_core_write,
  input  logic [31:0] i_core_addr,
  input  logic [31:0] i_disruptive_area,
  output logic        o_trigger
);

`ifdef A23_FLUSH_DISRUPTIVE_EN
  logic [4:0] region;
  logic       disruptive_wr;
  // Only the region field of the address matters here.
  logic       unused_addr_bits;

  assign unused_addr_bits = &{1'b0, i_core_addr[31:REGION_MSB+1], i_core_addr[REGION_LSB-1:0]};
  assign region           = i_core_addr[REGION_MSB:REGION_LSB];
  // Fires on hit or miss alike; reads never disturb the cache contents.
  assign disruptive_wr    = i_core_req & i_core_write & i_disruptive_area[region];
  assign o_trigger        = i_flush_req | disruptive_wr;
`else
  // Core access inputs are intentionally ignored in this build.
  logic unused_core_inputs;

  assign unused_core_inputs = &{1'b0, i_core_req, i_core_write, i_core_addr, i_disruptive_area};
  assign o_trigger          = i_flush_req;
`endif

endmodule

// File: rtl/a23_cache_flush_ctrl.sv
// Whole-cache invalidation sequencer. Sweeps every line index writing
// valid=0 to all ways, holding the pipeline stalled until the sweep is done.
// Reset itself starts a sweep because the tag RAM has no reset.
// Build option: A23_FLUSH_DISRUPTIVE_EN (see a23_flush_trigger).
module a23_cache_flush_ctrl
  import a23_cache_pkg::*;
#(
  parameter  int LINES  = A23_CACHE_LINES,
  parameter  int WAYS   = A23_CACHE_WAYS,
  localparam int LINE_W = $clog2(LINES)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush_req,
  input  logic              i_core_req,
  input  logic              i_core_write,
  input  logic [31:0]       i_core_addr,
  input  logic [31:0]       i_disruptive_area,
  input  logic              i_fill_busy,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_tag_wr_en,
  output logic [LINE_W-1:0] o_tag_wr_addr,
  output logic [WAYS-1:0]   o_tag_wr_ways,
  output logic              o_flush_done
);

  localparam logic [LINE_W-1:0] LAST_IDX = LINE_W'(LINES - 1);

  flush_state_e      state_q, state_d;
  logic [LINE_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              trigger;

  a23_flush_trigger u_trigger (
    .i_flush_req       (i_flush_req),
    .i_core_req        (i_core_req),
    .i_core_write      (i_core_write),
    .i_core_addr       (i_core_addr),
    .i_disruptive_area (i_disruptive_area),
    .o_trigger         (trigger)
  );

  // Next state and sweep index; triggers outside IDLE are simply absorbed.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          if (i_fill_busy) begin
            state_d = ST_WAIT_FILL;
          end else begin
            state_d = ST_SWEEP;
            idx_d   = '0;
          end
        end
      end
      ST_WAIT_FILL: begin
        if (!i_fill_busy) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
        end
      end
      ST_SWEEP: begin
        // Index holds at the last line rather than wrapping.
        if (idx_q == LAST_IDX) state_d = ST_DONE;
        else                   idx_d   = idx_q + LINE_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers; reset parks the FSM at the start of a sweep.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_SWEEP;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Tag writes and done are masked while reset is held so nothing is written
  // before the sweep actually begins.
  assign o_tag_wr_en   = (state_q == ST_SWEEP) & ~i_reset;
  assign o_tag_wr_addr = idx_q;
  assign o_tag_wr_ways = {WAYS{o_tag_wr_en}};
  assign o_flush_done  = (state_q == ST_DONE) & ~i_reset;
  assign o_busy        = busy_q;
  // Combinational from trigger so the triggering access itself is stalled.
  assign o_stall       = i_reset | busy_q | trigger;

endmodule

// File: tb/tb_a23_cache_flush_ctrl.sv
// Scoreboard bench for a23_cache_flush_ctrl with LINES=8. The stimulus
// thread pushes expected tag writes / done pulses (with their cycle) into a
// queue; the monitor pops and compares whenever the DUT emits one.
module tb_a23_cache_flush_ctrl;

  localparam int LINES  = 8;
  localparam int WAYS   = 4;
  localparam int LINE_W = $clog2(LINES);

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_flush_req;
  logic              i_core_req;
  logic              i_core_write;
  logic [31:0]       i_core_addr;
  logic [31:0]       i_disruptive_area;
  logic              i_fill_busy;
  logic              o_stall;
  logic              o_busy;
  logic              o_tag_wr_en;
  logic [LINE_W-1:0] o_tag_wr_addr;
  logic [WAYS-1:0]   o_tag_wr_ways;
  logic              o_flush_done;

  a23_cache_flush_ctrl #(.LINES(LINES), .WAYS(WAYS)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_flush_req       (i_flush_req),
    .i_core_req        (i_core_req),
    .i_core_write      (i_core_write),
    .i_core_addr       (i_core_addr),
    .i_disruptive_area (i_disruptive_area),
    .i_fill_busy       (i_fill_busy),
    .o_stall           (o_stall),
    .o_busy            (o_busy),
    .o_tag_wr_en       (o_tag_wr_en),
    .o_tag_wr_addr     (o_tag_wr_addr),
    .o_tag_wr_ways     (o_tag_wr_ways),
    .o_flush_done      (o_flush_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit is_done;
    int addr;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, actual, expected);
    end
  endtask

  task automatic push_write(input int addr, input int at);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = addr;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  task automatic push_done(input int at);
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = 0;
    e.cyc     = at;
    sb.push_back(e);
  endtask

  // Full sweep: writes to lines 0..LINES-1 from cycle 'start', done right after.
  task automatic expect_sweep(input int start);
    for (int i = 0; i < LINES; i++) push_write(i, start + i);
    push_done(start + LINES);
  endtask

  // Monitor: every tag write or done pulse must match the queue head.
  always @(negedge i_clk) begin
    if (o_tag_wr_en === 1'b1 || o_flush_done === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected cyc=%0d got wr=%0b addr=%0d done=%0b expected no event",
                 cyc, o_tag_wr_en, o_tag_wr_addr, o_flush_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_tag_wr_en === e.is_done || o_flush_done !== e.is_done || e.cyc != cyc ||
            (!e.is_done && (int'(o_tag_wr_addr) != e.addr || o_tag_wr_ways !== {WAYS{1'b1}}))) begin
          miscompares++;
          $display("FAIL sb_event cyc=%0d got wr=%0b addr=%0d ways=%b done=%0b expected done=%0b addr=%0d cyc=%0d",
                   cyc, o_tag_wr_en, o_tag_wr_addr, o_tag_wr_ways, o_flush_done,
                   e.is_done, e.addr, e.cyc);
        end
      end
    end
  end

  task automatic next();
    @(posedge i_clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) next();
  endtask

  task automatic sample_at(input int c);
    goto(c);
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, t1, t2, t3, t4, t5;
    i_reset = 1'b1;
    i_flush_req = 1'b0;
    i_core_req = 1'b0;
    i_core_write = 1'b0;
    i_core_addr = '0;
    i_disruptive_area = '0;
    i_fill_busy = 1'b0;

    // Reset values
    sample_at(3);
    check("rst_stall", o_stall, 1);
    check("rst_busy", o_busy, 1);
    check("rst_wr_en", o_tag_wr_en, 0);
    check("rst_wr_addr", o_tag_wr_addr, 0);
    check("rst_wr_ways", o_tag_wr_ways, 0);
    check("rst_done", o_flush_done, 0);

    // Reset release sweeps all lines
    r = 4;
    goto(r);
    expect_sweep(r);
    i_reset = 1'b0;
    sample_at(r + LINES);
    check("post_rst_stall_done", o_stall, 1);
    sample_at(r + LINES + 1);
    check("post_rst_stall_low", o_stall, 0);
    check("post_rst_busy_low", o_busy, 0);

    // CP15 flush pulse in IDLE
    t1 = r + LINES + 3;
    goto(t1);
    i_flush_req = 1'b1;
    expect_sweep(t1 + 1);
    @(negedge i_clk);
    check("flush_stall_same_cycle", o_stall, 1);
    check("flush_busy_same_cycle", o_busy, 0);
    goto(t1 + 1);
    i_flush_req = 1'b0;
    sample_at(t1 + LINES + 1);
    check("flush_stall_last", o_stall, 1);
    sample_at(t1 + LINES + 2);
    check("flush_stall_released", o_stall, 0);

    // Flush with a line fill busy for 3 cycles
    t2 = t1 + LINES + 4;
    goto(t2);
    i_flush_req = 1'b1;
    i_fill_busy = 1'b1;
    expect_sweep(t2 + 4);
    goto(t2 + 1);
    i_flush_req = 1'b0;
    sample_at(t2 + 2);
    check("fill_wait_busy", o_busy, 1);
    check("fill_wait_stall", o_stall, 1);
    check("fill_wait_no_wr", o_tag_wr_en, 0);
    goto(t2 + 3);
    i_fill_busy = 1'b0;
    sample_at(t2 + LINES + 4);
    check("fill_stall_last", o_stall, 1);
    sample_at(t2 + LINES + 5);
    check("fill_stall_released", o_stall, 0);

    // Disruptive-region writes (region 2 marked)
    t3 = t2 + LINES + 7;
    goto(t3);
    i_disruptive_area = 32'h0000_0004;
    i_core_req = 1'b1;
    i_core_write = 1'b0;
    i_core_addr = 32'h0040_0000;
    @(negedge i_clk);
    check("disr_read_no_stall", o_stall, 0);
    goto(t3 + 1);
    i_core_req = 1'b0;
    goto(t3 + 2);
    i_core_req = 1'b1;
    i_core_write = 1'b1;
    i_core_addr = 32'h0020_0000;
    @(negedge i_clk);
    check("disr_other_region_no_stall", o_stall, 0);
    goto(t3 + 3);
    i_core_req = 1'b0;
    goto(t3 + 4);
    i_core_req = 1'b1;
    i_core_write = 1'b1;
    i_core_addr = 32'h0040_0000;
`ifdef A23_FLUSH_DISRUPTIVE_EN
    expect_sweep(t3 + 5);
    @(negedge i_clk);
    check("disr_write_stall", o_stall, 1);
`else
    @(negedge i_clk);
    check("disr_write_disabled_no_stall", o_stall, 0);
`endif
    goto(t3 + 5);
    i_core_req = 1'b0;
    i_core_write = 1'b0;
    sample_at(t3 + 6);
`ifdef A23_FLUSH_DISRUPTIVE_EN
    check("disr_write_busy", o_busy, 1);
`else
    check("disr_write_disabled_busy", o_busy, 0);
`endif

    // Second flush during SWEEP and another during DONE are absorbed
    t4 = t3 + LINES + 7;
    goto(t4);
    i_flush_req = 1'b1;
    expect_sweep(t4 + 1);
    goto(t4 + 1);
    i_flush_req = 1'b0;
    goto(t4 + 4);
    i_flush_req = 1'b1;
    goto(t4 + 5);
    i_flush_req = 1'b0;
    goto(t4 + LINES + 1);
    i_flush_req = 1'b1;
    goto(t4 + LINES + 2);
    i_flush_req = 1'b0;
    @(negedge i_clk);
    check("absorbed_idle_stall", o_stall, 0);
    check("absorbed_idle_busy", o_busy, 0);

    // Reset asserted at sweep line 5 restarts from line 0
    t5 = t4 + LINES + 4;
    goto(t5);
    i_flush_req = 1'b1;
    for (int i = 0; i < 5; i++) push_write(i, t5 + 1 + i);
    goto(t5 + 1);
    i_flush_req = 1'b0;
    goto(t5 + 6);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("midrst_wr_en_drop", o_tag_wr_en, 0);
    sample_at(t5 + 7);
    check("midrst_wr_en", o_tag_wr_en, 0);
    check("midrst_wr_addr", o_tag_wr_addr, 0);
    check("midrst_stall", o_stall, 1);
    check("midrst_done", o_flush_done, 0);
    goto(t5 + 8);
    expect_sweep(t5 + 8);
    i_reset = 1'b0;
    sample_at(t5 + 8 + LINES + 1);
    check("midrst_stall_released", o_stall, 0);

    sample_at(t5 + 8 + LINES + 4);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
